// File: rtl/demux_1to8_seq.sv
// demux_1to8_seq: sequential 1-to-8 demultiplexer / deserializer.
// Receiving end of the 8-to-1 select-mux path. Select value k lands in
// y[7-k], so a mux driven by an incrementing select round-trips bit-exact.
//
// Modes
//   manual (auto=0): y[7-s] <= d on every enabled cycle.
//   auto   (auto=1): bits are collected into a frame buffer under an internal
//                    slot counter; the 8th bit loads the whole frame into y
//                    and pulses valid for one cycle.
//
// Ports
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   en     in   write enable; nothing changes while low
//   d      in   serial data bit
//   s      in   [2:0] slot select (manual mode)
//   auto   in   1 = auto-sequencing, 0 = manual
//   y      out  [7:0] registered parallel output
//   valid  out  one-cycle pulse when an auto frame is loaded into y
//   idx    out  [2:0] auto slot counter
//   abort  out  one-cycle pulse when a partial auto frame is discarded
//               (present only when DEMUX_ABORT_FLAG_EN is defined)
//
// Optional build macro: DEMUX_ABORT_FLAG_EN adds the abort output.
// Without it, abort handling is identical but not flagged.
module demux_1to8_seq #(
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       d,
  input  logic [2:0] s,
  input  logic       auto,
  output logic [7:0] y,
  output logic       valid,
  output logic [2:0] idx
`ifdef DEMUX_ABORT_FLAG_EN
  ,
  output logic       abort
`endif
);

  localparam logic [2:0] LAST = 3'd7;

  logic [7:0] frame_buf, frame_buf_nxt;
  logic [7:0] y_nxt;
  logic [2:0] idx_nxt;
  logic       valid_nxt;
  logic       abort_nxt;

  always_comb begin
    y_nxt         = y;
    frame_buf_nxt = frame_buf;
    idx_nxt       = idx;
    valid_nxt     = 1'b0;
    abort_nxt     = 1'b0;
    if (en) begin
      if (!auto) begin
        // idx is only ever nonzero inside an auto frame, so a nonzero idx in
        // manual mode means auto just fell mid-frame: discard the partial
        // frame and drop this cycle's manual write.
        if (idx != 3'd0) begin
          frame_buf_nxt = RST_VAL;
          idx_nxt       = 3'd0;
          abort_nxt     = 1'b1;
        end else begin
          y_nxt[LAST - s] = d;
        end
      end else if (idx == LAST) begin
        // Last bit bypasses the buffer so y is valid one cycle after it.
        y_nxt         = {frame_buf[7:1], d};
        frame_buf_nxt = RST_VAL;
        idx_nxt       = 3'd0;
        valid_nxt     = 1'b1;
      end else begin
        frame_buf_nxt[LAST - idx] = d;
        idx_nxt                   = idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y         <= RST_VAL;
      frame_buf <= RST_VAL;
      idx       <= 3'd0;
      valid     <= 1'b0;
    end else begin
      y         <= y_nxt;
      frame_buf <= frame_buf_nxt;
      idx       <= idx_nxt;
      valid     <= valid_nxt;
    end
  end

`ifdef DEMUX_ABORT_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) abort <= 1'b0;
    else     abort <= abort_nxt;
  end
`else
  // abort_nxt has no consumer in this build.
  logic unused_abort;
  assign unused_abort = abort_nxt;
`endif

endmodule

// File: tb/tb_demux_1to8_seq.sv
module tb_demux_1to8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, d, auto;
  logic [2:0] s;
  logic [7:0] y;
  logic       valid;
  logic [2:0] idx;
`ifdef DEMUX_ABORT_FLAG_EN
  logic       abort;
`endif

  int checks   = 0;
  int failures = 0;

  demux_1to8_seq #(.RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .s(s), .auto(auto),
    .y(y), .valid(valid), .idx(idx)
`ifdef DEMUX_ABORT_FLAG_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: auto bits are a queue of received bits; a full queue of
  // eight becomes y with the first-received bit in y[7]. Switching to manual
  // with a non-empty queue discards it.
  logic [7:0] m_y;
  logic       m_valid, m_abort;
  bit         q[$];

  initial begin
    m_y = 8'h00; m_valid = 1'b0; m_abort = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_y = 8'h00; m_valid = 1'b0; m_abort = 1'b0; q.delete();
      end else begin
        m_valid = 1'b0; m_abort = 1'b0;
        if (en) begin
          if (auto) begin
            q.push_back(d);
            if (q.size() == 8) begin
              for (int i = 0; i < 8; i++) m_y[7-i] = q[i];
              m_valid = 1'b1;
              q.delete();
            end
          end else if (q.size() != 0) begin
            q.delete();
            m_abort = 1'b1;
          end else begin
            m_y[7 - int'(s)] = d;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("y_vs_model", {24'd0, y}, {24'd0, m_y});
    chk("valid_vs_model", {31'd0, valid}, {31'd0, m_valid});
    chk("idx_vs_model", {29'd0, idx}, q.size());
`ifdef DEMUX_ABORT_FLAG_EN
    chk("abort_vs_model", {31'd0, abort}, {31'd0, m_abort});
`endif
  end

  task automatic drive(input logic e, input logic dd, input logic [2:0] ss, input logic a);
    en = e; d = dd; s = ss; auto = a;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) drive(1'b1, bits[i], 3'd0, 1'b1);
  endtask

  logic [7:0] frm;
  logic       a_r;

  initial begin
    rst = 1'b1; en = 1'b0; d = 1'b0; s = 3'd0; auto = 1'b0;
    @(posedge clk); #1;
    chk("reset_y", {24'd0, y}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_idx", {29'd0, idx}, 32'd0);
    rst = 1'b0;

    // Manual writes
    drive(1, 1, 3'd0, 0);
    drive(1, 1, 3'd3, 0);
    drive(1, 1, 3'd7, 0);
    chk("manual_y", {24'd0, y}, 32'h91);
    chk("manual_valid", {31'd0, valid}, 32'd0);
    chk("manual_idx", {29'd0, idx}, 32'd0);

    // Fill to FF, then assert reset mid-cycle
    for (int k = 0; k < 8; k++) drive(1, 1, 3'(k), 0);
    chk("manual_ff", {24'd0, y}, 32'hFF);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_y", {24'd0, y}, 32'h00);
    chk("async_reset_idx", {29'd0, idx}, 32'd0);
    chk("async_reset_valid", {31'd0, valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Auto frame 1,0,1,1,0,0,1,0
    frm = 8'b1011_0010;
    for (int i = 7; i >= 1; i--) drive(1, frm[i], 3'd0, 1);
    chk("auto_y_hold_7", {24'd0, y}, 32'h00);
    chk("auto_valid_7", {31'd0, valid}, 32'd0);
    chk("auto_idx_7", {29'd0, idx}, 32'd7);
    drive(1, frm[0], 3'd0, 1);
    chk("auto_y_8", {24'd0, y}, 32'hB2);
    chk("auto_valid_8", {31'd0, valid}, 32'd1);
    chk("auto_idx_8", {29'd0, idx}, 32'd0);
    drive(0, 0, 3'd0, 1);
    chk("auto_valid_drop", {31'd0, valid}, 32'd0);

    // Same frame with a 3-cycle gap after bit 4, then all-ones back-to-back
    for (int i = 7; i >= 4; i--) drive(1, frm[i], 3'd0, 1);
    for (int g = 0; g < 3; g++) begin
      drive(0, 1, 3'd5, 1);
      chk("gap_idx", {29'd0, idx}, 32'd4);
      chk("gap_y", {24'd0, y}, 32'hB2);
    end
    for (int i = 3; i >= 0; i--) drive(1, frm[i], 3'd0, 1);
    chk("gap_frame_y", {24'd0, y}, 32'hB2);
    chk("gap_frame_valid", {31'd0, valid}, 32'd1);
    for (int i = 0; i < 7; i++) drive(1, 1, 3'd0, 1);
    chk("b2b_valid_7", {31'd0, valid}, 32'd0);
    drive(1, 1, 3'd0, 1);
    chk("b2b_y", {24'd0, y}, 32'hFF);
    chk("b2b_valid", {31'd0, valid}, 32'd1);

    // Abort: 5 bits then manual write in the same cycle auto falls
    for (int i = 0; i < 5; i++) drive(1, 0, 3'd0, 1);
    chk("pre_abort_idx", {29'd0, idx}, 32'd5);
    drive(1, 0, 3'd0, 0);
    chk("abort_idx", {29'd0, idx}, 32'd0);
    chk("abort_y_hold", {24'd0, y}, 32'hFF);
    chk("abort_valid", {31'd0, valid}, 32'd0);
`ifdef DEMUX_ABORT_FLAG_EN
    chk("abort_flag", {31'd0, abort}, 32'd1);
`endif
    drive(1, 0, 3'd7, 0);
    chk("post_abort_manual", {24'd0, y}, 32'hFE);
`ifdef DEMUX_ABORT_FLAG_EN
    chk("abort_flag_drop", {31'd0, abort}, 32'd0);
`endif

    // Frame then disable hold with toggling inputs
    send_frame(8'hB2);
    chk("hold_frame_y", {24'd0, y}, 32'hB2);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'($urandom), 3'($urandom), 1'($urandom));
      chk("hold_y", {24'd0, y}, 32'hB2);
      chk("hold_idx", {29'd0, idx}, 32'd0);
      chk("hold_valid", {31'd0, valid}, 32'd0);
    end

    // Randomized run, checked every cycle by the compare process
    a_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) a_r = ~a_r;
      drive(1'($urandom_range(3) != 0), 1'($urandom), 3'($urandom), a_r);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1to8_seq.md
Name: demux_1to8_seq

Overview:
- Sequential 1-to-8 demultiplexer/deserializer; the receiving end of the 8-to-1 select-mux path.
- Routes a serial 1-bit input into eight registered output slots.
- Slot mapping: select 3'b000 -> y[7], ..., select 3'b111 -> y[0]. This mirrors the mux, so a mux driven by an incrementing select round-trips through this block bit-exact.
- Two modes:
  - Manual: external select.
  - Auto: internal slot counter with frame buffering and a valid pulse.

Parameters:
- RST_VAL, 8'h00, reset and abort value of y and of the internal frame buffer.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  write enable; d is sampled only when en=1.
- d  input  1  serial data bit.
- s  input  3  slot select, manual mode only.
- auto  input  1  1 = auto-sequencing mode, 0 = manual mode.
- y  output  8  registered parallel output.
- valid  output  1  one-cycle pulse: a complete auto frame was loaded into y.
- idx  output  3  current auto slot counter value.

Behaviour:
- Reset (rst=1, asynchronous): y=RST_VAL, buf=RST_VAL, idx=3'd0, valid=0. Held while rst=1. Normal operation resumes at the first rising edge after rst falls.
- Slot index function: slot(k) = 7-k, for k = s or k = idx.
- en=0 (either mode): no write; y, buf and idx hold; valid=0.
- Manual mode (auto=0, en=1):
  - y[slot(s)] <= d; all other y bits hold.
  - buf is untouched and idx is held at 0.
  - valid stays 0.
- Auto mode (auto=1, en=1), idx = 0..6:
  - buf[slot(idx)] <= d; idx <= idx+1.
  - y holds; valid=0.
- Auto mode, idx = 7 (frame completion):
  - y <= {buf[7:1], d} (bit 0 is the current d).
  - buf <= RST_VAL; idx wraps to 0; valid <= 1 for exactly one cycle.
- Latency: y and valid update at the same edge that samples the 8th bit, so they are visible 1 cycle after that bit is presented.
- Back-to-back frames are supported with no gap cycle. The next frame's first bit may be sampled the cycle valid is high.
- Mode switch 1->0 mid-frame (idx != 0), i.e. abort:
  - At the next edge: buf <= RST_VAL, idx <= 0; y holds; valid=0.
  - This takes priority over any manual write that same cycle; the manual write is dropped.
- Mode switch 0->1: auto frame starts at idx=0 with buf as left by the last abort/reset.
- Select mapping is independent of y's previous contents. No X is ever driven: a disabled block holds its last value.

Optional Feature:
- Macro: DEMUX_ABORT_FLAG_EN.
- Defined:
  - Adds output port abort (1 bit, reset 0).
  - abort pulses high for one cycle at the edge where an auto frame is discarded (auto falls while idx != 0).
  - Abort with idx=0 does not pulse.
- Undefined: port absent; abort handling otherwise identical.

Test Plan:
- Reset: assert rst mid-cycle with y=8'hFF -> y=8'h00, idx=0, valid=0 immediately (asynchronous, not at next edge).
- Manual: auto=0, en=1, (s,d) = (0,1), (3,1), (7,1) on three cycles -> y=8'h91; valid stays 0; idx=0.
- Auto frame: auto=1, en=1, d = 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> y stays 8'h00 through the 7th bit. At the 8th edge y=8'hB2, valid=1 for one cycle, idx back to 0.
- Gaps and back-to-back: same frame with en=0 inserted for 3 cycles after bit 4 -> idx holds at 4, y unchanged. Result 8'hB2 with valid. Then immediately d=all 1s for 8 cycles -> y=8'hFF, second valid pulse exactly 8 enabled cycles later.
- Abort: auto frame, 5 bits sent, then auto=0 with en=1, s=0, d=1 -> idx=0, y unchanged (manual write dropped), valid=0. With DEMUX_ABORT_FLAG_EN: abort=1 for one cycle. Next manual write behaves normally.
- Disable hold: after a frame, en=0 for 10 cycles with toggling d/s/auto=1 -> y, idx unchanged; valid=0 throughout.
